ldpc_iter_ctrl: RTL and testbench

Iteration controller for the LDPC decoder core. It sequences the check node units (CNUs) over the parity-check row groups of one codeword, and times the processing element (PE) write-back of CNU results to match the CNU register stage. It accumulates CNU parity bits into a per-iteration syndrome, triggers the PE variable-node update, and stops on a clean syndrome or when the iteration budget is exhausted. It sits between the decoder top-level start/done handshake and the CNU/PE array.

---
 rtl/ldpc_pkg.sv | 23 ++
 rtl/ldpc_pipe_delay.sv | 30 +++
 rtl/ldpc_iter_ctrl.sv | 134 +++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and CNU geometry for the LDPC decoder core.
// Optional abort support in ldpc_iter_ctrl is enabled by LDPC_ITER_CTRL_ABORT_EN.
package ldpc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_DRAIN = 3'd2,
        S_EVAL  = 3'd3,
        S_VAR   = 3'd4,
        S_DONE  = 3'd5
    } ldpc_ctrl_state_t;

    localparam int CNU_DEG = 6;
    localparam int MSG_W   = 6;
    localparam int MAG_W   = 4;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldpc_pipe_delay.sv
// Fixed-depth shift register with synchronous clear; aligns CNU enables
// with the CNU result register stage.
module ldpc_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: CHECK/DRAIN/EVAL/VAR sequencing with syndrome
// accumulation. Handshake: start is accepted only while busy=0; each accepted
// start yields exactly one done pulse, with success/iter_count valid from that
// cycle until the next accepted start. LDPC_ITER_CTRL_ABORT_EN adds abort.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int NUM_ROWS = 8,
    parameter int MAX_ITER = 10,
    parameter int CNU_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef LDPC_ITER_CTRL_ABORT_EN
    input  logic                          abort,
`endif
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          success,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
    output logic                          cnu_en,
    output logic [$clog2(NUM_ROWS)-1:0]   row_addr,
    input  logic                          p_bit,
    output logic                          pe_wr_en,
    output logic [$clog2(NUM_ROWS)-1:0]   pe_wr_addr,
    output logic                          vnu_en,
    output ldpc_ctrl_state_t              dbg_state
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int IW = $clog2(MAX_ITER+1);
    localparam int DW = cnt_w(CNU_LAT);

    ldpc_ctrl_state_t state_q, state_d;
    logic [RW-1:0]    row_q;
    logic [IW-1:0]    iter_q;
    logic [DW-1:0]    drain_q;
    logic             success_q;
    logic             syn_q;
    logic             abort_hit;
    logic             pipe_clr;
    logic             row_last;
    logic             iter_last;

`ifdef LDPC_ITER_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q inside {S_CHECK, S_DRAIN, S_EVAL, S_VAR});
`else
    assign abort_hit = 1'b0;
`endif

    assign row_last  = (row_q == RW'(NUM_ROWS-1));
    assign iter_last = (iter_q == IW'(MAX_ITER-1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: if (row_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DW'(CNU_LAT-1)) state_d = S_EVAL;
            S_EVAL:  state_d = (!syn_q || iter_last) ? S_DONE : S_VAR;
            S_VAR:   state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            iter_q    <= '0;
            drain_q   <= '0;
            success_q <= 1'b0;
            syn_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // p_bit only carries meaning on write-back cycles.
            if (pe_wr_en) syn_q <= syn_q | p_bit;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q     <= '0;
                        iter_q    <= '0;
                        drain_q   <= '0;
                        success_q <= 1'b0;
                        syn_q     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    row_q   <= row_last ? '0 : row_q + 1'b1;
                    drain_q <= '0;
                end
                S_DRAIN: drain_q <= drain_q + 1'b1;
                S_EVAL: begin
                    if (!abort_hit) begin
                        iter_q    <= iter_q + 1'b1;
                        success_q <= !syn_q;
                    end
                end
                S_VAR: syn_q <= 1'b0;
                default: ;
            endcase
            if (abort_hit) begin
                success_q <= 1'b0;
                row_q     <= '0;
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign vnu_en     = (state_q == S_VAR);
    assign cnu_en     = (state_q == S_CHECK);
    assign row_addr   = cnu_en ? row_q : '0;
    assign success    = success_q;
    assign iter_count = iter_q;
    assign dbg_state  = state_q;

    // Abort and reset both drop writes still in flight.
    assign pipe_clr = rst | abort_hit;

    ldpc_pipe_delay #(
        .WIDTH(RW + 1),
        .DEPTH(CNU_LAT)
    ) u_wr_delay (
        .clk (clk),
        .clr (pipe_clr),
        .din ({cnu_en, row_addr}),
        .dout({pe_wr_en, pe_wr_addr})
    );

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl (NUM_ROWS=4, MAX_ITER=3, CNU_LAT=1).
// Abort scenario is compiled in when LDPC_ITER_CTRL_ABORT_EN is defined.
module tb_ldpc_iter_ctrl;
    import ldpc_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             p_bit = 1'b0;
    logic             busy, done, success, cnu_en, pe_wr_en, vnu_en;
    logic [1:0]       iter_count, row_addr, pe_wr_addr;
    ldpc_ctrl_state_t dbg_state;
`ifdef LDPC_ITER_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    ldpc_iter_ctrl #(.NUM_ROWS(4), .MAX_ITER(3), .CNU_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef LDPC_ITER_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .busy      (busy),
        .done      (done),
        .success   (success),
        .iter_count(iter_count),
        .cnu_en    (cnu_en),
        .row_addr  (row_addr),
        .p_bit     (p_bit),
        .pe_wr_en  (pe_wr_en),
        .pe_wr_addr(pe_wr_addr),
        .vnu_en    (vnu_en),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  exp_q[$];
    logic [31:0] cnu_mask, pe_mask, vnu_mask, done_mask, busy_mask;
    logic [31:0] row_seq, done_success, done_iter, rst_vec, rst_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, done, success, iter_count, cnu_en, row_addr,
                    pe_wr_en, pe_wr_addr, vnu_en});
    endfunction

    // mode 0: p_bit=0; 1: p_bit=1; 2: 1 only on row-2 write of iteration 1;
    // 3: p_bit high only when no write is in progress.
    task automatic run_log(input int mode, input int ncyc, input bit hold,
                           input int rst_at, input int abort_at);
        int viter;
        viter     = 0;
        cnu_mask  = '0; pe_mask = '0; vnu_mask = '0; done_mask = '0; busy_mask = '0;
        row_seq   = '0; done_success = 32'hDEAD; done_iter = 32'hDEAD;
        rst_vec   = 32'hDEAD; rst_state = 32'hDEAD;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (cnu_en) begin
                cnu_mask[k] = 1'b1;
                row_seq = (row_seq << 2) | 32'(row_addr);
            end
            if (pe_wr_en) begin
                pe_mask[k] = 1'b1;
                if (exp_q.size() == 0) check_eq("pe_extra_write", 32'(pe_wr_addr), 32'hFFFF);
                else check_eq("pe_wr_addr", 32'(pe_wr_addr), 32'(exp_q.pop_front()));
            end
            if (vnu_en) vnu_mask[k] = 1'b1;
            if (busy) busy_mask[k] = 1'b1;
            if (done) begin
                done_mask[k] = 1'b1;
                done_success = 32'(success);
                done_iter    = 32'(iter_count);
            end
            if (k == rst_at + 1) begin
                rst_vec   = out_vec();
                rst_state = 32'(dbg_state);
            end
            case (mode)
                0: p_bit = 1'b0;
                1: p_bit = 1'b1;
                2: p_bit = (viter == 0) && pe_wr_en && (pe_wr_addr == 2'd2);
                default: p_bit = !pe_wr_en;
            endcase
            if (vnu_en) viter++;
            if (!hold || done) start = 1'b0;
            if (k == rst_at) rst = 1'b1;
            if (k == rst_at + 1) rst = 1'b0;
`ifdef LDPC_ITER_CTRL_ABORT_EN
            if (k == abort_at) abort = 1'b1;
            if (k == abort_at + 1) abort = 1'b0;
`endif
        end
        p_bit = 1'b0;
        start = 1'b0;
        check_eq("pe_writes_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic push_rows(input int n_iter);
        for (int it = 0; it < n_iter; it++)
            for (int r = 0; r < 4; r++) exp_q.push_back(2'(r));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 32'd0);
        check_eq("reset_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Clean first pass
        push_rows(1);
        run_log(0, 9, 1'b0, -10, -10);
        check_eq("t1_cnu_mask", cnu_mask, 32'h1E);
        check_eq("t1_row_seq", row_seq, 32'h1B);
        check_eq("t1_pe_mask", pe_mask, 32'h3C);
        check_eq("t1_vnu_mask", vnu_mask, 32'h0);
        check_eq("t1_done_mask", done_mask, 32'h80);
        check_eq("t1_busy_mask", busy_mask, 32'hFE);
        check_eq("t1_success", done_success, 32'd1);
        check_eq("t1_iter", done_iter, 32'd1);
        check_eq("t1_success_held", 32'(success), 32'd1);
        check_eq("t1_iter_held", 32'(iter_count), 32'd1);

        // Budget exhausted
        push_rows(3);
        run_log(1, 23, 1'b0, -10, -10);
        check_eq("t2_vnu_mask", vnu_mask, 32'h4080);
        check_eq("t2_cnu_mask", cnu_mask, 32'h78F1E);
        check_eq("t2_pe_mask", pe_mask, 32'hF1E3C);
        check_eq("t2_done_mask", done_mask, 32'h200000);
        check_eq("t2_success", done_success, 32'd0);
        check_eq("t2_iter", done_iter, 32'd3);

        // Single bad row in iteration 1
        push_rows(2);
        run_log(2, 16, 1'b0, -10, -10);
        check_eq("t3_vnu_mask", vnu_mask, 32'h80);
        check_eq("t3_done_mask", done_mask, 32'h4000);
        check_eq("t3_success", done_success, 32'd1);
        check_eq("t3_iter", done_iter, 32'd2);

        // p_bit noise outside write-back
        push_rows(1);
        run_log(3, 9, 1'b0, -10, -10);
        check_eq("t4_done_mask", done_mask, 32'h80);
        check_eq("t4_success", done_success, 32'd1);
        check_eq("t4_iter", done_iter, 32'd1);

        // Reset in cycle 3 with writes in flight
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        run_log(0, 5, 1'b0, 3, -10);
        check_eq("t5_rst_outputs", rst_vec, 32'd0);
        check_eq("t5_rst_state", rst_state, 32'(S_IDLE));
        check_eq("t5_pe_mask", pe_mask, 32'h0C);
        check_eq("t5_cnu_mask", cnu_mask, 32'h0E);
        check_eq("t5_done_mask", done_mask, 32'h0);

        // Restart in cycle 6 after reset
        push_rows(1);
        run_log(0, 9, 1'b0, -10, -10);
        check_eq("t6_cnu_mask", cnu_mask, 32'h1E);
        check_eq("t6_done_mask", done_mask, 32'h80);
        check_eq("t6_success", done_success, 32'd1);

        // start held through busy
        push_rows(1);
        run_log(0, 12, 1'b1, -10, -10);
        check_eq("t7_done_mask", done_mask, 32'h80);
        check_eq("t7_busy_mask", busy_mask, 32'hFE);
        check_eq("t7_cnu_mask", cnu_mask, 32'h1E);

`ifdef LDPC_ITER_CTRL_ABORT_EN
        // Abort in cycle 3
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        run_log(0, 7, 1'b0, -10, 3);
        check_eq("t8_done_mask", done_mask, 32'h10);
        check_eq("t8_success", done_success, 32'd0);
        check_eq("t8_iter", done_iter, 32'd0);
        check_eq("t8_pe_mask", pe_mask, 32'h0C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
